cue_shot_launcher: RTL and testbench

Consumes the oscillating cue power value produced while the player holds space. On release it latches the power, plays a short cue-strike animation, then issues a ball launch velocity that decays by friction once per frame. Sits between the cue power generator and the ball motion/drawing logic in the VGA pool-game pipeline.

---
 rtl/cue_shot_launcher.sv | 209 ++++++++++++++++++++
 tb/tb_cue_shot_launcher.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cue_shot_launcher.sv
// cue_shot_launcher
//
// Takes the oscillating cue power from the power generator while the
// player holds space. On release it latches a clamped copy of the power
// and plays a short cue-strike animation lasting STRIKE_FRAMES frame ticks.
// It then launches the ball at lp * SPEED_MULT and removes FRICTION speed
// units on every following frame tick until the ball stops.
//
// Ports
//   clk           system clock
//   resetN        asynchronous active-low reset
//   startOfFrame  frame strobe level; its falling edge is one frame tick
//   spacePressed  space key level
//   power         signed cue power from the power generator
//   dirX, dirY    signed cue unit direction, +/-64 == +/-1.0
//   cueOffset     cue pull-back distance in pixels, used for drawing
//   shotSpeed     current ball speed magnitude
//   velX, velY    signed ball velocity, lags shotSpeed by one cycle
//   ballMoving    high while shotSpeed != 0
//   shotValid     one-cycle pulse on the launch cycle
//   busy          high in CHARGING, STRIKE and ROLLING
module cue_shot_launcher #(
  parameter int POWER_MIN     = 2,
  parameter int POWER_MAX     = 120,
  parameter int SPEED_MULT    = 4,
  parameter int FRICTION      = 2,
  parameter int STRIKE_FRAMES = 6
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               spacePressed,
  input  logic signed [31:0] power,
  input  logic signed [7:0]  dirX,
  input  logic signed [7:0]  dirY,
  output logic [7:0]         cueOffset,
  output logic [15:0]        shotSpeed,
  output logic signed [15:0] velX,
  output logic signed [15:0] velY,
  output logic               ballMoving,
  output logic               shotValid,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHARGING,
    S_STRIKE,
    S_ROLLING
  } state_t;

  // Negative and oversized powers both land inside [POWER_MIN, POWER_MAX].
  function automatic logic [7:0] clamp_power(input logic signed [31:0] p);
    logic [7:0] r;
    if (p < POWER_MIN) begin
      r = 8'(POWER_MIN);
    end else if (p > POWER_MAX) begin
      r = 8'(POWER_MAX);
    end else begin
      r = p[7:0];
    end
    return r;
  endfunction

  // Speed times direction in 24-bit signed arithmetic. The arithmetic
  // shift floors toward minus infinity, so -337.5 becomes -338.
  function automatic logic signed [15:0] scale_vel(input logic [15:0]        spd,
                                                   input logic signed [7:0]  dir);
    logic signed [23:0] s_ext;
    logic signed [23:0] d_ext;
    logic signed [23:0] prod;
    logic signed [23:0] shifted;
    s_ext   = {8'd0, spd};
    d_ext   = {{16{dir[7]}}, dir};
    prod    = s_ext * d_ext;
    shifted = prod >>> 6;
    return shifted[15:0];
  endfunction

  state_t             state_q, state_d;
  logic               sof_q, sof_d;
  logic               space_q, space_d;
  logic [7:0]         cue_offset_q, cue_offset_d;
  logic [15:0]        shot_speed_q, shot_speed_d;
  logic signed [15:0] vel_x_q, vel_x_d;
  logic signed [15:0] vel_y_q, vel_y_d;
  logic               ball_moving_q, ball_moving_d;
  logic               shot_valid_q, shot_valid_d;
  logic               busy_q, busy_d;
  logic [7:0]         lp_q, lp_d;
  logic [7:0]         cnt_q, cnt_d;

  logic       tick;
  logic       space_rise;
  logic       space_fall;
  logic [7:0] cp;

  // Frame tick is the falling edge of startOfFrame. The space copy resets
  // to 0, so space held through reset is seen as a fresh press.
  assign tick       = sof_q & ~startOfFrame;
  assign space_rise = spacePressed & ~space_q;
  assign space_fall = ~spacePressed & space_q;
  assign cp         = clamp_power(power);

  always_comb begin
    state_d      = state_q;
    sof_d        = startOfFrame;
    space_d      = spacePressed;
    cue_offset_d = cue_offset_q;
    shot_speed_d = shot_speed_q;
    lp_d         = lp_q;
    cnt_d        = cnt_q;
    shot_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cue_offset_d = 8'd0;
        shot_speed_d = 16'd0;
        if (space_rise) begin
          state_d = S_CHARGING;
        end
      end

      S_CHARGING: begin
        cue_offset_d = cp >> 1;
        // A tick on the release cycle is ignored here, so it never counts.
        if (space_fall) begin
          lp_d    = cp;
          cnt_d   = 8'd0;
          state_d = S_STRIKE;
        end
      end

      S_STRIKE: begin
        if (tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(STRIKE_FRAMES)) begin
            cue_offset_d = 8'd0;
            shot_speed_d = 16'(lp_q) * 16'(SPEED_MULT);
            shot_valid_d = 1'b1;
            state_d      = S_ROLLING;
          end else begin
            cue_offset_d = cue_offset_q >> 1;
          end
        end
      end

      S_ROLLING: begin
        if (tick) begin
          if (shot_speed_q > 16'(FRICTION)) begin
            shot_speed_d = shot_speed_q - 16'(FRICTION);
          end else begin
            shot_speed_d = 16'd0;
            state_d      = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ball_moving_d = (shot_speed_d != 16'd0);
    busy_d        = (state_d != S_IDLE);
    // Velocity is one stage behind the registered speed.
    vel_x_d       = scale_vel(shot_speed_q, dirX);
    vel_y_d       = scale_vel(shot_speed_q, dirY);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      sof_q         <= 1'b0;
      space_q       <= 1'b0;
      cue_offset_q  <= 8'd0;
      shot_speed_q  <= 16'd0;
      vel_x_q       <= 16'sd0;
      vel_y_q       <= 16'sd0;
      ball_moving_q <= 1'b0;
      shot_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      lp_q          <= 8'd0;
      cnt_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      sof_q         <= sof_d;
      space_q       <= space_d;
      cue_offset_q  <= cue_offset_d;
      shot_speed_q  <= shot_speed_d;
      vel_x_q       <= vel_x_d;
      vel_y_q       <= vel_y_d;
      ball_moving_q <= ball_moving_d;
      shot_valid_q  <= shot_valid_d;
      busy_q        <= busy_d;
      lp_q          <= lp_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cueOffset  = cue_offset_q;
  assign shotSpeed  = shot_speed_q;
  assign velX       = vel_x_q;
  assign velY       = vel_y_q;
  assign ballMoving = ball_moving_q;
  assign shotValid  = shot_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cue_shot_launcher.sv
module tb_cue_shot_launcher;

  logic               clk;
  logic               resetN;
  logic               startOfFrame;
  logic               spacePressed;
  logic signed [31:0] power;
  logic signed [7:0]  dirX;
  logic signed [7:0]  dirY;
  logic [7:0]         cueOffset;
  logic [15:0]        shotSpeed;
  logic signed [15:0] velX;
  logic signed [15:0] velY;
  logic               ballMoving;
  logic               shotValid;
  logic               busy;

  int n_checks;
  int n_fail;

  cue_shot_launcher dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .spacePressed(spacePressed),
    .power       (power),
    .dirX        (dirX),
    .dirY        (dirY),
    .cueOffset   (cueOffset),
    .shotSpeed   (shotSpeed),
    .velX        (velX),
    .velY        (velY),
    .ballMoving  (ballMoving),
    .shotValid   (shotValid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame tick; returns just after the edge that acts on it.
  task automatic frame_tick();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " cueOffset"}, 32'(cueOffset), 0);
    check_eq({tag, " shotSpeed"}, 32'(shotSpeed), 0);
    check_eq({tag, " velX"}, 32'(velX), 0);
    check_eq({tag, " velY"}, 32'(velY), 0);
    check_eq({tag, " ballMoving"}, 32'(ballMoving), 0);
    check_eq({tag, " shotValid"}, 32'(shotValid), 0);
    check_eq({tag, " busy"}, 32'(busy), 0);
  endtask

  int cue_seq [5] = '{15, 7, 3, 1, 0};
  int exp_roll [4] = '{6, 4, 2, 0};

  initial begin
    int n;
    n_checks     = 0;
    n_fail       = 0;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    spacePressed = 1'b0;
    power        = 32'sd60;
    dirX         = 8'sd64;
    dirY         = 8'sd0;

    // Reset state
    step();
    step();
    check_all_zero("reset");
    resetN = 1'b1;
    step();
    check_all_zero("post_reset");

    // Test 1: power 60, dir (64,0), release coincident with a tick
    spacePressed = 1'b1;
    step();
    check_eq("t1 busy charging", 32'(busy), 1);
    step();
    check_eq("t1 cue charging", 32'(cueOffset), 30);
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    spacePressed = 1'b0;
    step();
    check_eq("t1 cue at release", 32'(cueOffset), 30);
    check_eq("t1 valid at release", 32'(shotValid), 0);
    for (int i = 0; i < 5; i++) begin
      frame_tick();
      check_eq($sformatf("t1 strike cue %0d", i + 1), 32'(cueOffset), cue_seq[i]);
      check_eq($sformatf("t1 strike valid %0d", i + 1), 32'(shotValid), 0);
    end
    frame_tick();
    check_eq("t1 shotValid", 32'(shotValid), 1);
    check_eq("t1 shotSpeed", 32'(shotSpeed), 240);
    check_eq("t1 cue forced", 32'(cueOffset), 0);
    check_eq("t1 ballMoving", 32'(ballMoving), 1);
    check_eq("t1 velX lag", 32'(velX), 0);
    step();
    check_eq("t1 velX", 32'(velX), 240);
    check_eq("t1 velY", 32'(velY), 0);
    check_eq("t1 valid pulse", 32'(shotValid), 0);

    // Rolling to stop while toggling space; space ends held high
    n = 0;
    while (shotSpeed != 16'd0 && n < 200) begin
      spacePressed = (n >= 110) ? 1'b1 : 1'((n % 2) == 1);
      frame_tick();
      n++;
    end
    check_eq("t1 roll ticks", n, 120);
    check_eq("t1 end speed", 32'(shotSpeed), 0);
    check_eq("t1 end moving", 32'(ballMoving), 0);
    check_eq("t1 end busy", 32'(busy), 0);
    check_eq("t1 velX last", 32'(velX), 2);
    step();
    check_eq("t1 velX zero", 32'(velX), 0);
    step();
    step();
    check_eq("t1 held space idle", 32'(busy), 0);
    spacePressed = 1'b0;
    step();

    // Test 2: clamp high, dir (-45,45), space toggles during STRIKE
    power = 32'sd200;
    dirX  = -8'sd45;
    dirY  = 8'sd45;
    spacePressed = 1'b1;
    step();
    step();
    check_eq("t2 cue charging", 32'(cueOffset), 60);
    spacePressed = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      spacePressed = 1'((i % 2) == 0);
      frame_tick();
      check_eq($sformatf("t2 strike busy %0d", i + 1), 32'(busy), 1);
    end
    spacePressed = 1'b0;
    frame_tick();
    check_eq("t2 shotValid", 32'(shotValid), 1);
    check_eq("t2 shotSpeed", 32'(shotSpeed), 480);
    step();
    check_eq("t2 velX", 32'(velX), -338);
    check_eq("t2 velY", 32'(velY), 337);
    n = 0;
    while (busy && n < 300) begin
      frame_tick();
      n++;
    end
    check_eq("t2 roll ticks", n, 240);
    step();

    // Test 3: clamp low
    power = -32'sd5;
    dirX  = 8'sd64;
    dirY  = 8'sd0;
    spacePressed = 1'b1;
    step();
    step();
    check_eq("t3 cue charging", 32'(cueOffset), 1);
    spacePressed = 1'b0;
    step();
    for (int i = 0; i < 6; i++) frame_tick();
    check_eq("t3 shotValid", 32'(shotValid), 1);
    check_eq("t3 shotSpeed", 32'(shotSpeed), 8);
    step();
    check_eq("t3 velX", 32'(velX), 8);
    for (int i = 0; i < 4; i++) begin
      frame_tick();
      check_eq($sformatf("t3 speed %0d", i + 1), 32'(shotSpeed), exp_roll[i]);
      check_eq($sformatf("t3 moving %0d", i + 1), 32'(ballMoving), (i < 3) ? 1 : 0);
    end
    check_eq("t3 idle", 32'(busy), 0);
    step();

    // Test 4: asynchronous reset mid-ROLLING at speed 100
    power = 32'sd30;
    spacePressed = 1'b1;
    step();
    step();
    spacePressed = 1'b0;
    step();
    for (int i = 0; i < 6; i++) frame_tick();
    check_eq("t4 launch speed", 32'(shotSpeed), 120);
    for (int i = 0; i < 10; i++) frame_tick();
    check_eq("t4 speed before reset", 32'(shotSpeed), 100);
    spacePressed = 1'b1;
    #2;
    resetN = 1'b0;
    #1;
    check_all_zero("t4 async reset");
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("t4 no valid %0d", i), 32'(shotValid), 0);
    end
    resetN = 1'b1;
    step();
    check_eq("t4 charging after reset", 32'(busy), 1);
    step();
    check_eq("t4 cue after reset", 32'(cueOffset), 15);
    check_eq("t4 no launch", 32'(shotSpeed), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
